// File: rtl/ramdumper.sv
// ramdumper: streams a byte range of the 64-bit data RAM out on a
// valid/ready byte port after the CPU halts.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, base, len  dump request (sampled in IDLE), first byte, count
//   abort             cancel the current dump, no done pulse
//   addr, addr_en     RAM byte address and bus-ownership request
//   rdata             RAM read data, byte k = mem[addr + k]
//   tx_data/valid/rdy outgoing byte stream
//   busy, done        activity flag, one-cycle completion pulse
module ramdumper #(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [15:0]   len,
    input  logic          abort,
    output logic [AW-1:0] addr,
    output logic          addr_en,
    input  logic [DW-1:0] rdata,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   rem_q, rem_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] sreg_q, sreg_d;

    logic xfer;
    logic last_byte;
    logic word_end;

    assign xfer      = (state_q == S_SEND) && tx_ready;
    assign last_byte = (rem_q == 16'd1);
    // A word ends on its 8th byte or on the last byte of the dump.
    assign word_end  = xfer && ((cnt_q == 3'd7) || last_byte);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == 16'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_SEND;
            S_SEND: begin
                if (word_end) begin
                    state_d = last_byte ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Output logic
    always_comb begin
        addr     = '0;
        addr_en  = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_FETCH, S_LATCH: begin
                addr    = ptr_q;
                addr_en = 1'b1;
                busy    = 1'b1;
            end
            S_SEND: begin
                tx_data  = sreg_q[7:0];
                tx_valid = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: pointer, byte counters, shift register
    always_comb begin
        ptr_d  = ptr_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        if ((state_q == S_IDLE) && start) begin
            ptr_d = base;
            rem_d = len;
            cnt_d = 3'd0;
        end
        if (state_q == S_LATCH) begin
            sreg_d = rdata;
        end
        if (xfer) begin
            sreg_d = sreg_q >> 8;
            rem_d  = rem_q - 16'd1;
            cnt_d  = cnt_q + 3'd1;
            if (word_end) begin
                // Pointer arithmetic wraps naturally at 2^AW.
                ptr_d = ptr_q + AW'(8);
                cnt_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            sreg_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            sreg_q <= sreg_d;
        end
    end

endmodule
